// File: rtl/dep_pkg.sv
// dep_pkg: widths, register-mask encode and dependency-term helpers for dep_tracker. Rev 1.0
// FALSE_DEP_TRACK_EN adds WAR/WAW terms to the dependency function.
`default_nettype none

package dep_pkg;
  localparam int DEF_BS     = 32;
  localparam int DEF_REGNUM = 16;
  localparam int DEF_NSRC   = 2;
  localparam int RW = $clog2(DEF_REGNUM);
  localparam int IW = $clog2(DEF_BS);
  localparam int CW = IW + 1;

`ifdef FALSE_DEP_TRACK_EN
  localparam bit FALSE_DEP = 1'b1;
`else
  localparam bit FALSE_DEP = 1'b0;
`endif

  // One bit of a register mask; register 0 never sets a bit.
  function automatic logic reg_hit(input int r, input int i);
    return (r != 0) && (r == i);
  endfunction

  function automatic logic dep_term(input logic raw, input logic war, input logic waw);
    return raw | (FALSE_DEP & (war | waw));
  endfunction
endpackage

`default_nettype wire

// File: rtl/dep_row_cmp.sv
// dep_row_cmp: one window slot's column bit of the dependency row being inserted. Rev 1.0
`default_nettype none

module dep_row_cmp
  import dep_pkg::*;
#(
  parameter int REGNUM = 16
) (
  input  logic              slot_valid,
  input  logic              retiring,
  input  logic [REGNUM-1:0] new_rd,
  input  logic [REGNUM-1:0] new_rs,
  input  logic [REGNUM-1:0] old_rd,
  input  logic [REGNUM-1:0] old_rs,
  output logic              dep_bit
);
  logic w_raw, w_war, w_waw;

  assign w_raw = |(new_rs & old_rd);
  assign w_war = |(new_rd & old_rs);
  assign w_waw = |(new_rd & old_rd);

  // A slot retiring this cycle never becomes a producer of the new entry.
  assign dep_bit = slot_valid && !retiring && dep_term(w_raw, w_war, w_waw);
endmodule

`default_nettype wire

// File: rtl/dep_tracker.sv
// dep_tracker: circular in-order window of register masks with per-slot dependency rows. Rev 1.0
// Build option FALSE_DEP_TRACK_EN: also track WAR/WAW dependencies (default RAW only).
`default_nettype none

module dep_tracker
  import dep_pkg::*;
#(
  parameter int BS     = DEF_BS,
  parameter int REGNUM = DEF_REGNUM,
  parameter int NSRC   = DEF_NSRC,
  localparam int RWL   = $clog2(REGNUM),
  localparam int IWL   = $clog2(BS),
  localparam int CWL   = IWL + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_valid,
  output logic                ins_ready,
  input  logic [RWL-1:0]      ins_rd,
  input  logic [NSRC*RWL-1:0] ins_rs,
  output logic [IWL-1:0]      ins_idx,
  input  logic                ret_valid,
  output logic [BS-1:0]       indep,
  output logic [CWL-1:0]      count,
  output logic                full,
  output logic                empty
);
  logic [BS-1:0]     r_valid;
  logic [BS-1:0]     r_dep [BS];
  logic [REGNUM-1:0] r_rdm [BS];
  logic [REGNUM-1:0] r_rsm [BS];
  logic [IWL-1:0]    r_head, r_tail;
  logic [CWL-1:0]    r_count;

  logic [REGNUM-1:0] w_rdm, w_rsm;
  logic [BS-1:0]     w_new_row;
  logic              w_ins, w_ret;

  always_comb begin
    w_rdm = '0;
    w_rsm = '0;
    for (int i = 0; i < REGNUM; i++) begin
      w_rdm[i] = reg_hit(32'(ins_rd), i);
      for (int k = 0; k < NSRC; k++) begin
        w_rsm[i] = w_rsm[i] | reg_hit(32'(ins_rs[k*RWL +: RWL]), i);
      end
    end
  end

  assign full      = (r_count == CWL'(BS));
  assign empty     = (r_count == '0);
  assign ins_ready = !full;
  assign ins_idx   = r_tail;
  assign count     = r_count;
  assign w_ins     = ins_valid && !full;
  assign w_ret     = ret_valid && !empty;

  generate
    for (genvar j = 0; j < BS; j++) begin : g_slot
      dep_row_cmp #(.REGNUM(REGNUM)) u_cmp (
        .slot_valid (r_valid[j] && (IWL'(j) != r_tail)),
        .retiring   (w_ret && (IWL'(j) == r_head)),
        .new_rd     (w_rdm),
        .new_rs     (w_rsm),
        .old_rd     (r_rdm[j]),
        .old_rs     (r_rsm[j]),
        .dep_bit    (w_new_row[j])
      );
    end
  endgenerate

  always_comb begin
    indep = '0;
    for (int i = 0; i < BS; i++) begin
      indep[i] = r_valid[i] && ~|r_dep[i];
    end
  end

  // Insert and retire never target the same slot: that needs full (no insert) or empty (no retire).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < BS; i++) begin
        r_dep[i] <= '0;
        r_rdm[i] <= '0;
        r_rsm[i] <= '0;
      end
    end else begin
      if (w_ret) begin
        for (int i = 0; i < BS; i++) begin
          r_dep[i][r_head] <= 1'b0;
        end
        r_dep[r_head]   <= '0;
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_ins) begin
        r_dep[r_tail]   <= w_new_row;
        r_rdm[r_tail]   <= w_rdm;
        r_rsm[r_tail]   <= w_rsm;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CWL'(w_ins) - CWL'(w_ret);
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_dep_tracker.sv
// tb_dep_tracker: directed and random stimulus for dep_tracker against a program-order queue model.
`default_nettype none

module tb_dep_tracker;
  localparam int BS = 4;
  localparam int REGNUM = 16;
  localparam int NSRC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ins_valid = 1'b0;
  logic       ins_ready;
  logic [3:0] ins_rd = '0;
  logic [7:0] ins_rs = '0;
  logic [1:0] ins_idx;
  logic       ret_valid = 1'b0;
  logic [3:0] indep;
  logic [2:0] count;
  logic       full;
  logic       empty;

  dep_tracker #(.BS(BS), .REGNUM(REGNUM), .NSRC(NSRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_rd    (ins_rd),
    .ins_rs    (ins_rs),
    .ins_idx   (ins_idx),
    .ret_valid (ret_valid),
    .indep     (indep),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int slot;
    int rd;
    int rs0;
    int rs1;
    int seq;
    bit has_dep;
    int dep_max;
  } ent_t;

  ent_t q[$];
  int   nseq = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit conflict(ent_t n, ent_t o);
    bit raw;
    raw = (n.rs0 != 0 && n.rs0 == o.rd) || (n.rs1 != 0 && n.rs1 == o.rd);
`ifdef FALSE_DEP_TRACK_EN
    begin
      bit war, waw;
      war = (n.rd != 0) && (n.rd == o.rs0 || n.rd == o.rs1);
      waw = (n.rd != 0) && (n.rd == o.rd);
      return raw || war || waw;
    end
`else
    return raw;
`endif
  endfunction

  // An entry is free once every entry it conflicted with (all older) has left the queue.
  function automatic logic [31:0] model_indep();
    logic [31:0] e;
    e = '0;
    foreach (q[k]) begin
      if (!q[k].has_dep || q[k].dep_max < q[0].seq) e[q[k].slot] = 1'b1;
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), q.size());
    check({tag, ".full"}, 32'(full), 32'(q.size() == BS));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".ready"}, 32'(ins_ready), 32'(q.size() != BS));
    check({tag, ".idx"}, 32'(ins_idx), nseq % BS);
    check({tag, ".indep"}, 32'(indep), model_indep());
  endtask

  task automatic do_cycle(input string tag, input bit iv, input int rd, input int rs0,
                          input int rs1, input bit rv);
    bit   acc_i, acc_r;
    ent_t e;
    ins_valid = iv;
    ins_rd    = 4'(rd);
    ins_rs    = {4'(rs1), 4'(rs0)};
    ret_valid = rv;
    acc_i = iv && (q.size() < BS);
    acc_r = rv && (q.size() > 0);
    @(posedge clk);
    if (acc_r) void'(q.pop_front());
    if (acc_i) begin
      e.slot = nseq % BS;
      e.rd = rd;
      e.rs0 = rs0;
      e.rs1 = rs1;
      e.seq = nseq;
      e.has_dep = 1'b0;
      e.dep_max = -1;
      foreach (q[k]) begin
        if (conflict(e, q[k])) begin
          e.has_dep = 1'b1;
          e.dep_max = q[k].seq;
        end
      end
      q.push_back(e);
      nseq++;
    end
    #1;
    ins_valid = 1'b0;
    ret_valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    q.delete();
    nseq = 0;
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".empty"}, 32'(empty), 1);
    check({tag, ".full"}, 32'(full), 0);
    check({tag, ".ready"}, 32'(ins_ready), 1);
    check({tag, ".idx"}, 32'(ins_idx), 0);
    check({tag, ".indep"}, 32'(indep), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_outputs({tag, ".post"});
  endtask

  initial begin
    apply_reset("reset0");

    // RAW chain, then retire of the producer frees the consumer.
    do_cycle("raw.a", 1, 3, 1, 2, 0);
    check("raw.a_bits", 32'(indep), 32'b0001);
    do_cycle("raw.b", 1, 4, 3, 0, 0);
    check("raw.b_bits", 32'(indep), 32'b0001);
    do_cycle("raw.ret", 0, 0, 0, 0, 1);
    check("raw.ret_bits", 32'(indep), 32'b0010);
    do_cycle("raw.drain", 0, 0, 0, 0, 1);

    // Register 0 is never a producer.
    do_cycle("x0.a", 1, 0, 5, 0, 0);
    do_cycle("x0.b", 1, 6, 0, 0, 0);
    check("x0.bits", 32'(indep), 32'b1100);
    do_cycle("x0.d1", 0, 0, 0, 0, 1);
    do_cycle("x0.d2", 0, 0, 0, 0, 1);

    // WAR/WAW pair lands in slots 0 and 1.
    do_cycle("war.a", 1, 2, 1, 0, 0);
    do_cycle("war.b", 1, 1, 7, 0, 0);
`ifdef FALSE_DEP_TRACK_EN
    check("war.bits", 32'(indep), 32'b0001);
`else
    check("war.bits", 32'(indep), 32'b0011);
`endif
    do_cycle("war.d1", 0, 0, 0, 0, 1);
    do_cycle("war.d2", 0, 0, 0, 0, 1);

    // Consumer inserted in the same cycle its producer retires is independent.
    do_cycle("rw.prod", 1, 5, 0, 0, 0);
    do_cycle("rw.cons", 1, 9, 5, 0, 1);
    check("rw.bits", 32'(indep), 32'b1000);
    do_cycle("rw.d", 0, 0, 0, 0, 1);

    // Fill to full, drop an insert, no same-cycle bypass, then wrap the tail.
    for (int i = 0; i < BS; i++) do_cycle("fill", 1, 8 + i, 0, 0, 0);
    check("fill.full", 32'(full), 1);
    do_cycle("drop", 1, 2, 3, 0, 0);
    check("drop.count", 32'(count), 4);
    check("drop.idx", 32'(ins_idx), 0);
    do_cycle("nobypass", 1, 2, 3, 0, 1);
    check("nobypass.count", 32'(count), 3);
    do_cycle("wrap", 1, 2, 3, 0, 0);
    check("wrap.idx", 32'(ins_idx), 1);
    check("wrap.count", 32'(count), 4);

    // Mid-stream reset with a populated window.
    apply_reset("reset1");

    for (int c = 0; c < 600; c++) begin
      do_cycle("rand", ($urandom_range(0, 99) < 60), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 99) < 45));
      if (c == 300) apply_reset("reset2");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
